sync_down_counter: RTL

- Loadable synchronous down counter / countdown timer. Mirror of the 4-bit synchronous up counter.
- Counts from a loaded value down to zero. Flags terminal count, then either stops or auto-reloads.
- Serves as the generic countdown/timeout primitive for the other blocks in the design.
- A small FSM adds start, stop/pause and resume control.

---
 rtl/sync_down_counter_pkg.sv | 21 ++
 rtl/sync_down_counter_cnt_ctrl_fsm.sv | 72 +++++++
 rtl/sync_down_counter.sv | 65 ++++++
 3 files changed

// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the countdown counters: FSM states, datapath
// operations and the default counter width.
package sync_down_counter_pkg;

    localparam int DEFAULT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cnt_state_t;

    typedef enum logic [1:0] {
        CNT_HOLD   = 2'd0,
        CNT_LOAD   = 2'd1,
        CNT_DEC    = 2'd2,
        CNT_RELOAD = 2'd3
    } cnt_op_t;

endpackage

// File: rtl/sync_down_counter_cnt_ctrl_fsm.sv
// Control FSM of the down counter: owns the state register and decides
// what the datapath does to count on every edge.
module cnt_ctrl_fsm
    import sync_down_counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       auto_reload,
    input  logic       count_zero,
    input  logic       reload_zero,
    output cnt_state_t state,
    output cnt_op_t    op
);

    cnt_state_t next_state;

    // State register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath-op decode; load beats stop, stop beats start.
    always_comb begin
        next_state = state;
        op         = CNT_HOLD;
        if (load) begin
            next_state = IDLE;
            op         = CNT_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (!stop && start && !count_zero) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        next_state = PAUSE;
                    end else if (!count_zero) begin
                        op = CNT_DEC;
                    end else if (auto_reload && !reload_zero) begin
                        op = CNT_RELOAD;
                    end else begin
                        next_state = DONE;
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        next_state = RUN;
                    end
                end
                DONE: begin
                    if (!stop && start && !reload_zero) begin
                        next_state = RUN;
                        op         = CNT_RELOAD;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter / countdown timer with start, pause,
// resume and optional auto-reload on terminal count.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] reload_reg;
    cnt_state_t       state;
    cnt_op_t          op;
    logic             count_zero;
    logic             reload_zero;

    assign count_zero  = (count == '0);
    assign reload_zero = (reload_reg == '0);

    cnt_ctrl_fsm u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count_zero  (count_zero),
        .reload_zero (reload_zero),
        .state       (state),
        .op          (op)
    );

    // Count and reload registers follow the operation chosen by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            reload_reg <= '0;
        end else begin
            case (op)
                CNT_LOAD: begin
                    count      <= load_val;
                    reload_reg <= load_val;
                end
                CNT_DEC:    count <= count - WIDTH'(1);
                CNT_RELOAD: count <= reload_reg;
                default:    count <= count;
            endcase
        end
    end

    assign tc   = (state == RUN) && count_zero;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
